// File: rtl/fx_ci_cores.sv
// Behavioural stand-ins for the fp_add, fp_mult and cosine IP cores: fp32 in, fp32 out,
// fixed pipeline latency, en-gated, async areset. Arithmetic is done in double and
// rounded to nearest-even single; denormals flush to zero.
package fx_fp_model_pkg;

    function automatic real fp32_to_real(logic [31:0] v);
        logic [63:0] d;
        if (v[30:23] == 8'h00)
            d = {v[31], 63'd0};
        else if (v[30:23] == 8'hFF)
            d = {v[31], 11'h7FF, v[22:0], 29'd0};
        else
            d = {v[31], {3'b000, v[30:23]} + 11'd896, v[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] fp32_from_real(real r);
        logic [63:0] d;
        logic [24:0] m;
        logic        up;
        int          e;
        d = $realtobits(r);
        if (d[62:52] == 11'h7FF)
            return {d[63], 8'hFF, d[51:29] | {22'd0, |d[51:0]}};
        e = int'(d[62:52]) - 896;
        if (d[62:52] == 11'd0 || e <= 0)
            return {d[63], 31'd0};
        up = d[28] & (d[29] | (|d[27:0]));
        m  = {2'b01, d[51:29]} + {24'd0, up};
        if (m[24]) begin
            e = e + 1;
            m = m >> 1;
        end
        if (e >= 255)
            return {d[63], 8'hFF, 23'd0};
        return {d[63], e[7:0], m[22:0]};
    endfunction

endpackage

// Result pipeline shared by the core models.
module fx_fp_delay #(
    parameter int LAT = 3
) (
    input  logic        clk,
    input  logic        areset,
    input  logic        en,
    input  logic [31:0] d,
    output logic [31:0] q
);
    logic [31:0] pipe [LAT];

    // Shift the computed value through LAT stages while enabled.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else if (en) begin
            pipe[0] <= d;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[LAT-1];
endmodule

module fp_add import fx_fp_model_pkg::*; #(
    parameter int LAT = 3
) (
    input  logic        clk,
    input  logic        areset,
    input  logic        en,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] q
);
    logic [31:0] calc;

    // Rounded single-precision sum.
    always_comb calc = fp32_from_real(fp32_to_real(a) + fp32_to_real(b));

    fx_fp_delay #(.LAT(LAT)) u_pipe (.clk(clk), .areset(areset), .en(en), .d(calc), .q(q));
endmodule

module fp_mult import fx_fp_model_pkg::*; #(
    parameter int LAT = 3
) (
    input  logic        clk,
    input  logic        areset,
    input  logic        en,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] q
);
    logic [31:0] calc;

    // Rounded single-precision product.
    always_comb calc = fp32_from_real(fp32_to_real(a) * fp32_to_real(b));

    fx_fp_delay #(.LAT(LAT)) u_pipe (.clk(clk), .areset(areset), .en(en), .d(calc), .q(q));
endmodule

module cosine import fx_fp_model_pkg::*; #(
    parameter int LAT = 8
) (
    input  logic        clk,
    input  logic        areset,
    input  logic        en,
    input  logic [31:0] a,
    output logic [31:0] q
);
    logic [31:0] calc;

    // Rounded single-precision cosine of an angle in radians.
    always_comb calc = fp32_from_real($cos(fp32_to_real(a)));

    fx_fp_delay #(.LAT(LAT)) u_pipe (.clk(clk), .areset(areset), .en(en), .d(calc), .q(q));
endmodule

// File: rtl/fx_ci_pkg.sv
// Shared types, default constants and step-length helper for the f(x) evaluate/accumulate custom instruction.
package fx_ci_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADD1,
        MUL1,
        COS,
        MUL2,
        ADD2,
        ACC,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        EVAL      = 2'd0,
        EVAL_ACC  = 2'd1,
        READ_ACC  = 2'd2,
        CLEAR_ACC = 2'd3
    } op_t;

    localparam logic [31:0] FP_OFFSET_DEF = 32'hC300_0000;  // -128.0
    localparam logic [31:0] FP_SCALE_DEF  = 32'h3C00_0000;  // 1/128
    localparam logic [31:0] FP_HALF_DEF   = 32'h3F00_0000;  // 0.5

    localparam int LAT_ADD_DEF = 3;
    localparam int LAT_MUL_DEF = 3;
    localparam int LAT_COS_DEF = 8;

    localparam int TIMER_W = 8;

    // Wait length loaded into the step timer when a state is entered.
    function automatic logic [TIMER_W-1:0] step_length(state_t s, int lat_add, int lat_mul, int lat_cos);
        logic [TIMER_W-1:0] len;
        case (s)
            ADD1, ADD2, ACC: len = TIMER_W'(lat_add);
            MUL1, MUL2:      len = TIMER_W'(lat_mul);
            COS:             len = TIMER_W'(lat_cos);
            default:         len = '0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/fx_eval_acc_ci_step_timer.sv
// Per-state wait counter: loaded with L on state entry, flags the operand issue
// cycle (offset 0) and the result capture cycle (offset L).
module fx_step_timer import fx_ci_pkg::*; (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_en,
    input  logic               load,
    input  logic [TIMER_W-1:0] len,
    output logic               issue,
    output logic               capture,
    output logic [TIMER_W-1:0] count
);
    logic first;

    // Down-count to zero; count holds at zero between states.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
            first <= 1'b0;
        end else if (clk_en) begin
            if (load) begin
                count <= len;
                first <= 1'b1;
            end else begin
                first <= 1'b0;
                if (count != '0) count <= count - TIMER_W'(1);
            end
        end
    end

    assign issue   = first;
    assign capture = (count == '0);
endmodule

// File: rtl/fx_eval_acc_ci.sv
// f(x) = x/2 + x^2*cos((x + C_OFFSET)*C_SCALE) custom instruction with a running accumulator.
//
// state | meaning
// IDLE  | waiting for start; READ/CLEAR answer straight from here
// ADD1  | d = x + C_OFFSET
// MUL1  | angle = d * C_SCALE
// COS   | c = cos(angle); multiplier reused for x*x (offset 0) and x*C_HALF (offset 1)
// MUL2  | p = x2 * c
// ADD2  | f = half + p
// ACC   | acc = acc + f (EVAL_ACC only)
// DONE  | done pulse, result driven
module fx_eval_acc_ci import fx_ci_pkg::*; #(
    parameter int          LAT_ADD  = LAT_ADD_DEF,
    parameter int          LAT_MUL  = LAT_MUL_DEF,
    parameter int          LAT_COS  = LAT_COS_DEF,
    parameter logic [31:0] C_OFFSET = FP_OFFSET_DEF,
    parameter logic [31:0] C_SCALE  = FP_SCALE_DEF,
    parameter logic [31:0] C_HALF   = FP_HALF_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [1:0]  n,
    input  logic [31:0] dataa,
    output logic [31:0] result,
    output logic        done,
    output logic        busy
);
    if (LAT_ADD < 1 || LAT_MUL < 1) begin : g_bad_lat
        $error("LAT_ADD and LAT_MUL must be at least 1");
    end
    if (LAT_COS < LAT_MUL + 1) begin : g_bad_cos
        $error("LAT_COS must be at least LAT_MUL+1 so x*C_HALF completes inside COS");
    end
    if (LAT_ADD >= 2**TIMER_W || LAT_MUL >= 2**TIMER_W || LAT_COS >= 2**TIMER_W) begin : g_bad_width
        $error("core latency does not fit the step timer");
    end

    // Timer values seen at the in-COS multiplier offsets (timer counts down from LAT_COS).
    localparam logic [TIMER_W-1:0] CNT_HALF_ISSUE = TIMER_W'(LAT_COS - 1);
    localparam logic [TIMER_W-1:0] CNT_X2_CAP     = TIMER_W'(LAT_COS - LAT_MUL);
    localparam logic [TIMER_W-1:0] CNT_HALF_CAP   = TIMER_W'(LAT_COS - LAT_MUL - 1);

    state_t             state, state_next;
    op_t                op_q;
    logic [31:0]        x_q, d_q, angle_q, c_q, x2_q, half_q, p_q, acc_q, res_q;
    logic [31:0]        add_a, add_b, add_q, mul_a, mul_b, mul_q, cos_a, cos_q;
    logic               step_issue, step_capture, step_load;
    logic [TIMER_W-1:0] step_count, step_len;
    logic               core_areset;

    assign core_areset = ~reset;

    // State register; frozen while clk_en is low.
    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else if (clk_en)
            state <= state_next;
    end

    // Next state, core operands (zero outside issue cycles) and outputs.
    always_comb begin
        state_next = state;
        add_a      = '0;
        add_b      = '0;
        mul_a      = '0;
        mul_b      = '0;
        cos_a      = '0;
        case (state)
            IDLE: if (start) state_next = n[1] ? DONE : ADD1;
            ADD1: begin
                if (step_issue) begin add_a = x_q; add_b = C_OFFSET; end
                if (step_capture) state_next = MUL1;
            end
            MUL1: begin
                if (step_issue) begin mul_a = d_q; mul_b = C_SCALE; end
                if (step_capture) state_next = COS;
            end
            COS: begin
                if (step_issue) begin
                    cos_a = angle_q;
                    mul_a = x_q;
                    mul_b = x_q;
                end
                if (step_count == CNT_HALF_ISSUE) begin mul_a = x_q; mul_b = C_HALF; end
                if (step_capture) state_next = MUL2;
            end
            MUL2: begin
                if (step_issue) begin mul_a = x2_q; mul_b = c_q; end
                if (step_capture) state_next = ADD2;
            end
            ADD2: begin
                if (step_issue) begin add_a = half_q; add_b = p_q; end
                if (step_capture) state_next = (op_q == EVAL_ACC) ? ACC : DONE;
            end
            ACC: begin
                if (step_issue) begin add_a = acc_q; add_b = res_q; end
                if (step_capture) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        step_load = clk_en && (state_next != state);
        step_len  = step_length(state_next, LAT_ADD, LAT_MUL, LAT_COS);
        done      = (state == DONE);
        busy      = (state != IDLE);
        result    = done ? res_q : '0;
    end

    // Operand latches and per-state result captures.
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q    <= EVAL;
            x_q     <= '0;
            d_q     <= '0;
            angle_q <= '0;
            c_q     <= '0;
            x2_q    <= '0;
            half_q  <= '0;
            p_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
        end else if (clk_en) begin
            case (state)
                IDLE: if (start) begin
                    x_q  <= dataa;
                    op_q <= op_t'(n);
                    if (n[1]) res_q <= acc_q;
                    if (op_t'(n) == CLEAR_ACC) acc_q <= '0;
                end
                ADD1: if (step_capture) d_q <= add_q;
                MUL1: if (step_capture) angle_q <= mul_q;
                COS: begin
                    if (step_count == CNT_X2_CAP) x2_q <= mul_q;
                    if (step_count == CNT_HALF_CAP) half_q <= mul_q;
                    if (step_capture) c_q <= cos_q;
                end
                MUL2: if (step_capture) p_q <= mul_q;
                ADD2: if (step_capture) res_q <= add_q;
                ACC: if (step_capture) begin
                    acc_q <= add_q;
                    res_q <= add_q;
                end
                default: ;
            endcase
        end
    end

    fx_step_timer u_timer (
        .clk(clk), .reset(reset), .clk_en(clk_en),
        .load(step_load), .len(step_len),
        .issue(step_issue), .capture(step_capture), .count(step_count)
    );

    fp_add #(.LAT(LAT_ADD)) u_add (
        .clk(clk), .areset(core_areset), .en(clk_en), .a(add_a), .b(add_b), .q(add_q)
    );

    fp_mult #(.LAT(LAT_MUL)) u_mul (
        .clk(clk), .areset(core_areset), .en(clk_en), .a(mul_a), .b(mul_b), .q(mul_q)
    );

    cosine #(.LAT(LAT_COS)) u_cos (
        .clk(clk), .areset(core_areset), .en(clk_en), .a(cos_a), .q(cos_q)
    );
endmodule

// File: tb/tb_fx_eval_acc_ci.sv
// Bench for fx_eval_acc_ci: vector table, multi-cycle corner sequences and a random run
// against a real-arithmetic model of f(x) and the accumulator.
module tb_fx_eval_acc_ci;
    localparam int A1 = 3, M1 = 3, C1 = 8;
    localparam int A2 = 2, M2 = 4, C2 = 10;
    localparam int LAT_EVAL1 = 2*A1 + 2*M1 + C1 + 6;
    localparam int LAT_ACC1  = LAT_EVAL1 + A1 + 1;
    localparam int LAT_EVAL2 = 2*A2 + 2*M2 + C2 + 6;

    localparam logic [1:0] OP_EVAL = 2'd0, OP_EACC = 2'd1, OP_READ = 2'd2, OP_CLEAR = 2'd3;
    localparam logic [31:0] X128 = 32'h4300_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_en = 1'b1;
    logic        start = 1'b0, start2 = 1'b0;
    logic [1:0]  n = 2'd0, n2 = 2'd0;
    logic [31:0] dataa = 32'd0;
    logic [31:0] result, result2;
    logic        done, done2, busy, busy2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fx_eval_acc_ci dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .n(n),
        .dataa(dataa), .result(result), .done(done), .busy(busy)
    );

    fx_eval_acc_ci #(.LAT_ADD(A2), .LAT_MUL(M2), .LAT_COS(C2)) dut2 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .start(start2), .n(n2),
        .dataa(dataa), .result(result2), .done(done2), .busy(busy2)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] x;
        logic [31:0] exp_res;
        int          exp_lat;
        bit          any_zero_sign;
    } vec_t;

    vec_t tbl [9];

    function automatic real fp_val(logic [31:0] b);
        int  e;
        real m;
        e = int'(b[30:23]);
        if (e == 0) return 0.0;
        m = (1.0 + real'(int'(b[22:0])) / 8388608.0) * (2.0 ** (e - 127));
        return b[31] ? -m : m;
    endfunction

    function automatic real absr(real r);
        return (r < 0.0) ? -r : r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_near(input string name, input real act, input real exp, input real tol);
        total++;
        if (absr(act - exp) > tol) begin
            bad++;
            $display("FAIL %s: got %g want %g (tol %g)", name, act, exp, tol);
        end
    endtask

    // Issue one command and follow it to done. hs = {busy ok, result quiet before done, idle after done}.
    task automatic run_op(input int inst, input logic [1:0] op, input logic [31:0] x,
                          input int frz_lo, input int frz_hi, input bit noise,
                          output logic [31:0] res, output int lat, output logic [2:0] hs);
        logic b, d;
        logic [31:0] r;
        res = '0;
        lat = -1;
        hs  = 3'b111;
        @(negedge clk);
        if ((inst == 0 ? busy : busy2) !== 1'b0) hs[2] = 1'b0;
        if (inst == 0) begin start = 1'b1; n = op; end
        else begin start2 = 1'b1; n2 = op; end
        dataa = x;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            start  = 1'b0;
            start2 = 1'b0;
            b = (inst == 0) ? busy : busy2;
            d = (inst == 0) ? done : done2;
            r = (inst == 0) ? result : result2;
            if (b !== 1'b1) hs[2] = 1'b0;
            if (d === 1'b1) begin
                lat = k;
                res = r;
                break;
            end
            if (r !== 32'd0) hs[1] = 1'b0;
            if (noise) begin
                dataa = $urandom;
                if (k == 4) begin start = 1'b1; n = OP_CLEAR; end
            end
            clk_en = !(k >= frz_lo && k <= frz_hi);
        end
        clk_en = 1'b1;
        @(negedge clk);
        if (inst == 0) begin
            if (done !== 1'b0 || busy !== 1'b0 || result !== 32'd0) hs[0] = 1'b0;
        end else begin
            if (done2 !== 1'b0 || busy2 !== 1'b0 || result2 !== 32'd0) hs[0] = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res, x;
        logic [2:0]  hs;
        logic [1:0]  op;
        int          lat, exp_lat;
        bit          saw_done;
        real         xr, f, acc_ref, acc_mag, exp_r, tol;

        tbl[0] = '{OP_EVAL,  X128,          32'h4680_8000, LAT_EVAL1, 1'b0};
        tbl[1] = '{OP_CLEAR, 32'd0,         32'h0000_0000, 1,         1'b0};
        tbl[2] = '{OP_EACC,  X128,          32'h4680_8000, LAT_ACC1,  1'b0};
        tbl[3] = '{OP_EACC,  X128,          32'h4700_8000, LAT_ACC1,  1'b0};
        tbl[4] = '{OP_READ,  32'd0,         32'h4700_8000, 1,         1'b0};
        tbl[5] = '{OP_EVAL,  32'h0000_0000, 32'h0000_0000, LAT_EVAL1, 1'b1};
        tbl[6] = '{OP_READ,  32'd0,         32'h4700_8000, 1,         1'b0};
        tbl[7] = '{OP_CLEAR, 32'd0,         32'h4700_8000, 1,         1'b0};
        tbl[8] = '{OP_READ,  32'd0,         32'h0000_0000, 1,         1'b0};

        // Reset held for two cycles.
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {result[31:2], done, busy}, 32'd0);
        check("reset_result", result, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_op(0, tbl[i].op, tbl[i].x, 1000, 0, 1'b0, res, lat, hs);
            check($sformatf("vec%0d_result", i),
                  tbl[i].any_zero_sign ? (res & 32'h7FFF_FFFF) : res, tbl[i].exp_res);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].exp_lat));
            check($sformatf("vec%0d_handshake", i), {29'd0, hs}, 32'd7);
        end

        // x = 256: cos(1) term, checked against the closed form.
        run_op(0, OP_EVAL, 32'h4380_0000, 1000, 0, 1'b0, res, lat, hs);
        check_near("eval256_result", fp_val(res), 35537.25, 35537.25 * 1e-4);
        check("eval256_latency", 32'(lat), 32'(LAT_EVAL1));

        // Freeze cycles 10..14, stray start while busy, dataa churning after acceptance.
        run_op(0, OP_EVAL, X128, 10, 14, 1'b1, res, lat, hs);
        check("freeze_result", res, 32'h4680_8000);
        check("freeze_latency", 32'(lat), 32'(LAT_EVAL1 + 5));
        check("freeze_handshake", {29'd0, hs}, 32'd7);

        // Reset in the middle of an EVAL_ACC with acc = 16448.
        run_op(0, OP_EACC, X128, 1000, 0, 1'b0, res, lat, hs);
        check("preabort_acc", res, 32'h4680_8000);
        @(negedge clk);
        start = 1'b1; n = OP_EACC; dataa = X128;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("abort_outputs", {result[31:2], done, busy}, 32'd0);
        reset = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        check("abort_no_done", {31'd0, saw_done}, 32'd0);
        run_op(0, OP_READ, 32'd0, 1000, 0, 1'b0, res, lat, hs);
        check("abort_acc_cleared", res, 32'd0);
        check("abort_read_latency", 32'(lat), 32'd1);

        // Alternate latencies.
        run_op(1, OP_EVAL, X128, 1000, 0, 1'b0, res, lat, hs);
        check("lat2_result", res, 32'h4680_8000);
        check("lat2_latency", 32'(lat), 32'(LAT_EVAL2));
        check("lat2_handshake", {29'd0, hs}, 32'd7);

        // Random commands against the real-arithmetic model.
        acc_ref = 0.0;
        acc_mag = 0.0;
        for (int it = 0; it < 24; it++) begin
            op = 2'($urandom_range(0, 3));
            if (op == OP_CLEAR && ($urandom_range(0, 2) != 0)) op = OP_EACC;
            x  = {1'($urandom_range(0, 1)), 8'(120 + $urandom_range(0, 16)), 23'($urandom)};
            xr = fp_val(x);
            f  = xr / 2.0 + xr * xr * $cos((xr - 128.0) / 128.0);
            case (op)
                OP_EVAL: begin
                    exp_r   = f;
                    tol     = 1e-4 * (absr(xr) / 2.0 + xr * xr) + 1e-6;
                    exp_lat = LAT_EVAL1;
                end
                OP_EACC: begin
                    acc_ref = acc_ref + f;
                    acc_mag = acc_mag + absr(xr) / 2.0 + xr * xr;
                    exp_r   = acc_ref;
                    tol     = 1e-4 * acc_mag + 1e-6;
                    exp_lat = LAT_ACC1;
                end
                OP_READ: begin
                    exp_r   = acc_ref;
                    tol     = 1e-4 * acc_mag + 1e-6;
                    exp_lat = 1;
                end
                default: begin
                    exp_r   = acc_ref;
                    tol     = 1e-4 * acc_mag + 1e-6;
                    exp_lat = 1;
                    acc_ref = 0.0;
                    acc_mag = 0.0;
                end
            endcase
            run_op(0, op, x, 1000, 0, 1'b0, res, lat, hs);
            check_near($sformatf("rand%0d_op%0d_result", it, op), fp_val(res), exp_r, tol);
            check($sformatf("rand%0d_latency", it), 32'(lat), 32'(exp_lat));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
